// File: rtl/tinyml_buf_pkg.sv
// ============================================================================
// Module  : tinyml_buf_pkg
// Brief   : Shared types and constants for the vector tile buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tinyml_buf_pkg;

  localparam int ELEM_WIDTH          = 8;
  localparam int TILE_ELEMS          = 32;
  localparam int DEFAULT_NUM_BUFFERS = 4;
  localparam int DEFAULT_DEPTH_TILES = 25;
  localparam int BUF_ID_W            = 5;

  typedef logic [BUF_ID_W-1:0] buf_id_t;
  typedef logic signed [ELEM_WIDTH-1:0] tile_t [TILE_ELEMS];

endpackage

`default_nettype wire

// File: rtl/vector_tile_buffer_tile_ram.sv
// ============================================================================
// Module  : tile_ram
// Brief   : One write port, one registered read port, read-before-write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_ram #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read samples the array before this edge's write lands, so a same-address
  // collision returns the old word; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/vector_tile_buffer.sv
// ============================================================================
// Module  : vector_tile_buffer
// Brief   : Tile-granular streaming store with per-buffer auto-incrementing pointers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_tile_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_ELEMS  = tinyml_buf_pkg::TILE_ELEMS,
  parameter int NUM_BUFFERS = tinyml_buf_pkg::DEFAULT_NUM_BUFFERS,
  parameter int DEPTH_TILES = tinyml_buf_pkg::DEFAULT_DEPTH_TILES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vec_read_enable,
  input  tinyml_buf_pkg::buf_id_t       vec_read_buffer_id,
  output logic signed [DATA_WIDTH-1:0]  vec_read_tile [TILE_ELEMS],
  output logic                          vec_read_valid,
  input  logic                          vec_write_enable,
  input  tinyml_buf_pkg::buf_id_t       vec_write_buffer_id,
  input  logic signed [DATA_WIDTH-1:0]  vec_write_tile [TILE_ELEMS],
  input  logic                          rewind_enable,
  input  tinyml_buf_pkg::buf_id_t       rewind_buffer_id,
  output logic                          id_error
);

  import tinyml_buf_pkg::*;

  localparam int PTR_W   = (DEPTH_TILES > 1) ? $clog2(DEPTH_TILES) : 1;
  localparam int ENTRIES = NUM_BUFFERS * DEPTH_TILES;
  localparam int ADDR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int WORD_W  = DATA_WIDTH * TILE_ELEMS;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH_TILES - 1);

  logic [PTR_W-1:0]  rd_ptr [NUM_BUFFERS];
  logic [PTR_W-1:0]  wr_ptr [NUM_BUFFERS];
  logic              rd_ok, wr_ok, rw_ok;
  logic              rd_go, wr_go, rw_go;
  logic [PTR_W-1:0]  rd_cur, wr_cur;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic              zero_out;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_ok = 32'(vec_read_buffer_id)  < 32'(NUM_BUFFERS);
  assign wr_ok = 32'(vec_write_buffer_id) < 32'(NUM_BUFFERS);
  assign rw_ok = 32'(rewind_buffer_id)    < 32'(NUM_BUFFERS);
  assign rd_go = vec_read_enable  && rd_ok;
  assign wr_go = vec_write_enable && wr_ok;
  assign rw_go = rewind_enable    && rw_ok;

  // A rewind landing on the accessed buffer forces this cycle's address to tile 0.
  always_comb begin
    rd_cur = '0;
    wr_cur = '0;
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      if (32'(vec_read_buffer_id)  == 32'(b)) rd_cur = rd_ptr[b];
      if (32'(vec_write_buffer_id) == 32'(b)) wr_cur = wr_ptr[b];
    end
    if (rw_go && (rewind_buffer_id == vec_read_buffer_id))  rd_cur = '0;
    if (rw_go && (rewind_buffer_id == vec_write_buffer_id)) wr_cur = '0;
  end

  assign rd_addr = ADDR_W'(32'(vec_read_buffer_id)  * 32'(DEPTH_TILES) + 32'(rd_cur));
  assign wr_addr = ADDR_W'(32'(vec_write_buffer_id) * 32'(DEPTH_TILES) + 32'(wr_cur));

  for (genvar b = 0; b < NUM_BUFFERS; b++) begin : g_ptr
    logic [PTR_W-1:0] rd_q, wr_q;
    logic             rd_hit, wr_hit, rw_hit;

    assign rd_hit = rd_go && (32'(vec_read_buffer_id)  == 32'(b));
    assign wr_hit = wr_go && (32'(vec_write_buffer_id) == 32'(b));
    assign rw_hit = rw_go && (32'(rewind_buffer_id)    == 32'(b));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (rd_hit)      rd_q <= ptr_next(rd_cur);
        else if (rw_hit) rd_q <= '0;
        if (wr_hit)      wr_q <= ptr_next(wr_cur);
        else if (rw_hit) wr_q <= '0;
      end
    end

    assign rd_ptr[b] = rd_q;
    assign wr_ptr[b] = wr_q;
  end

  for (genvar i = 0; i < TILE_ELEMS; i++) begin : g_lanes
    assign wr_word[i*DATA_WIDTH +: DATA_WIDTH] = vec_write_tile[i];
    assign vec_read_tile[i] = zero_out ? '0 : rd_word[i*DATA_WIDTH +: DATA_WIDTH];
  end

  tile_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (ENTRIES),
    .ADDR_W (ADDR_W)
  ) u_tile_ram (
    .clk   (clk),
    .we    (wr_go),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (rd_go),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // The RAM word is never reset, so zero_out masks it until a real read lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_read_valid <= 1'b0;
      zero_out       <= 1'b1;
      id_error       <= 1'b0;
    end else begin
      vec_read_valid <= vec_read_enable;
      if (vec_read_enable) zero_out <= !rd_ok;
      if ((vec_read_enable && !rd_ok) || (vec_write_enable && !wr_ok) ||
          (rewind_enable && !rw_ok))
        id_error <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_tile_buffer.sv
// ============================================================================
// Module  : tb_vector_tile_buffer
// Brief   : Scoreboard bench for vector_tile_buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_tile_buffer;

  typedef struct {
    logic [255:0] tile;
    int           cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en, wr_en, rw_en;
  logic [4:0]        rd_id, wr_id, rw_id;
  logic [255:0]      wflat, rflat;
  logic signed [7:0] wtile [32];
  logic signed [7:0] rtile [32];
  logic              valid, id_err;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vector_tile_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .vec_read_enable     (rd_en),
    .vec_read_buffer_id  (rd_id),
    .vec_read_tile       (rtile),
    .vec_read_valid      (valid),
    .vec_write_enable    (wr_en),
    .vec_write_buffer_id (wr_id),
    .vec_write_tile      (wtile),
    .rewind_enable       (rw_en),
    .rewind_buffer_id    (rw_id),
    .id_error            (id_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 32; i++) wtile[i] = wflat[i*8 +: 8];
  end
  always_comb begin
    rflat = '0;
    for (int i = 0; i < 32; i++) rflat[i*8 +: 8] = rtile[i];
  end

  // Every valid pulse must match the oldest outstanding request, one edge after it.
  always @(posedge clk) begin
    #2;
    if (rst_n && valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d got valid=1 required 0", cyc);
      end else begin
        m_e = q.pop_front();
        if (rflat !== m_e.tile) begin
          errors++;
          $display("FAIL read_tile cyc=%0d got=%h exp=%h", cyc, rflat, m_e.tile);
        end
        checks++;
        if (cyc !== m_e.cyc) begin
          errors++;
          $display("FAIL read_latency got_cyc=%0d exp_cyc=%0d", cyc, m_e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] pat(input int base, input int step);
    logic [255:0] t;
    int v;
    for (int i = 0; i < 32; i++) begin
      v = base + i * step;
      t[i*8 +: 8] = v[7:0];
    end
    return t;
  endfunction

  task automatic drive(input logic r, input logic [4:0] rid, input logic [255:0] exp_tile,
                       input logic w, input logic [4:0] wid, input logic [255:0] wt,
                       input logic rw, input logic [4:0] rwid);
    exp_t e;
    @(negedge clk);
    rd_en = r;  rd_id = rid;
    wr_en = w;  wr_id = wid;  wflat = wt;
    rw_en = rw; rw_id = rwid;
    if (r) begin
      e.tile = exp_tile;
      e.cyc  = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic rd(input logic [4:0] id, input logic [255:0] exp_tile);
    drive(1'b1, id, exp_tile, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  task automatic wr(input logic [4:0] id, input logic [255:0] t);
    drive(1'b0, 5'd0, '0, 1'b1, id, t, 1'b0, 5'd0);
  endtask

  task automatic rew(input logic [4:0] id);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, id);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    rd_en = 0; wr_en = 0; rw_en = 0;
    rd_id = 0; wr_id = 0; rw_id = 0; wflat = '0;
    #12;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++;
    if (rflat !== '0) begin errors++; $display("FAIL reset_tile got=%h exp=0", rflat); end
    checks++;
    if (id_err !== 1'b0) begin errors++; $display("FAIL reset_id_error got=%b exp=0", id_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) wr(5'd1, pat(k*32 - 50, 1));
    rew(5'd1);
    for (int k = 0; k < 3; k++) rd(5'd1, pat(k*32 - 50, 1));
    idle();
    wait_drain();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL stream_pending got=%0d exp=0", q.size()); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 25; k++) wr(5'd0, pat(k, 0));
    wr(5'd0, pat(127, 0));
    rew(5'd0);
    rd(5'd0, pat(127, 0));
    rd(5'd0, pat(1, 0));
    idle();
    wait_drain();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL wrap_pending got=%0d exp=0", q.size()); end
  endtask

  task automatic test_same_cycle();
    rew(5'd2);
    wr(5'd2, pat(17, 1));
    rew(5'd2);
    drive(1'b1, 5'd2, pat(17, 1), 1'b1, 5'd2, pat(-3, 2), 1'b0, 5'd0);
    rew(5'd2);
    rd(5'd2, pat(-3, 2));
    wr(5'd2, pat(60, -1));
    wr(5'd2, pat(-100, 3));
    idle();
    wait_drain();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL same_cycle_pending got=%0d exp=0", q.size()); end
  endtask

  task automatic test_bad_id();
    rd(5'd9, '0);
    idle();
    wait_drain();
    checks++;
    if (id_err !== 1'b1) begin errors++; $display("FAIL bad_id_flag got=%b exp=1", id_err); end
    wr(5'd9, pat(99, 7));
    rew(5'd1);
    rd(5'd1, pat(-50, 1));
    idle();
    wait_drain();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL bad_id_pending got=%0d exp=0", q.size()); end
    checks++;
    if (id_err !== 1'b1) begin errors++; $display("FAIL bad_id_sticky got=%b exp=1", id_err); end
  endtask

  task automatic test_rewind_collide();
    for (int k = 0; k < 6; k++) wr(5'd3, pat(k*7 + 1, 1));
    for (int k = 0; k < 5; k++) rd(5'd3, pat(k*7 + 1, 1));
    drive(1'b1, 5'd3, pat(1, 1), 1'b0, 5'd0, '0, 1'b1, 5'd3);
    rd(5'd3, pat(8, 1));
    rd(5'd2, pat(-100, 3));
    wr(5'd2, pat(5, 5));
    rd(5'd2, pat(5, 5));
    idle();
    wait_drain();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL collide_pending got=%0d exp=0", q.size()); end
  endtask

  task automatic test_reset_midstream();
    rd(5'd3, pat(15, 1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", valid); end
    checks++;
    if (rflat !== '0) begin errors++; $display("FAIL midreset_tile got=%h exp=0", rflat); end
    checks++;
    if (id_err !== 1'b0) begin errors++; $display("FAIL midreset_id_error got=%b exp=0", id_err); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL midreset_pending got=%0d exp=0", q.size()); end
    q.delete();
    idle();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    rd(5'd3, pat(1, 1));
    rd(5'd3, pat(8, 1));
    rd(5'd2, pat(60, -1));
    idle();
    wait_drain();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL restart_pending got=%0d exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_same_cycle();
    test_bad_id();
    test_rewind_collide();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
